// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter fed directly from the TX FIFO head. While enabled it pops one word
// per frame and serialises start, LSB-first data and stop bits on oversample ticks.
module uart_tx_fifo_drain #(
  parameter int unsigned NB_DATA     = 8,
  parameter int unsigned N_TICK_BIT  = 16,
  parameter int unsigned N_STOP_BITS = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_enable,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_fifo_empty,
  output logic               o_read,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_tx_done
);

  localparam int unsigned TickW = $clog2(N_STOP_BITS * N_TICK_BIT);
  localparam int unsigned BitW  = $clog2(NB_DATA) + 1;

  localparam logic [TickW-1:0] BitTickLast  = TickW'(N_TICK_BIT - 1);
  localparam logic [TickW-1:0] StopTickLast = TickW'(N_STOP_BITS * N_TICK_BIT - 1);
  localparam logic [BitW-1:0]  DataBitLast  = BitW'(NB_DATA - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e             state_q, state_d;
  logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [NB_DATA-1:0] shreg_q, shreg_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic load;
  logic bit_end;
  logic stop_end;

  assign load     = (state_q == StIdle) && i_enable && !i_fifo_empty;
  assign bit_end  = i_tick && (tick_cnt_q == BitTickLast);
  assign stop_end = i_tick && (tick_cnt_q == StopTickLast);

  // Pop strobe is combinational so the FIFO advances on the same edge that latches the word;
  // it is held low while reset is asserted.
  assign o_read    = i_rst && load;
  assign o_tx      = tx_q;
  assign o_busy    = busy_q;
  assign o_tx_done = done_q;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        if (load) begin
          shreg_d = i_data;
          state_d = StStart;
        end
      end

      StStart: begin
        if (bit_end) begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = StData;
        end else if (i_tick) begin
          tick_cnt_d = tick_cnt_q + TickW'(1);
        end
      end

      StData: begin
        if (bit_end) begin
          tick_cnt_d = '0;
          shreg_d    = shreg_q >> 1;
          if (bit_cnt_q == DataBitLast) begin
            bit_cnt_d = '0;
            state_d   = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end else if (i_tick) begin
          tick_cnt_d = tick_cnt_q + TickW'(1);
        end
      end

      StStop: begin
        if (stop_end) begin
          tick_cnt_d = '0;
          done_d     = 1'b1;
          state_d    = StIdle;
        end else if (i_tick) begin
          tick_cnt_d = tick_cnt_q + TickW'(1);
        end
      end

      default: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        state_d    = StIdle;
      end
    endcase
  end

  // Line level follows the next state, so it changes on the edge entering a state or bit.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != StIdle);
    unique case (state_d)
      StIdle:  tx_d = 1'b1;
      StStart: tx_d = 1'b0;
      StData:  tx_d = shreg_d[0];
      StStop:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: FIFO models feed two instances (1 and 2 stop bits),
// expected line levels are derived from the ticks the bench itself generates.
module tb_uart_tx_fifo_drain;

  localparam int NTick = 16;

  logic clk;
  logic rst;
  logic tick;
  int   tick_div;
  int   tcnt;

  // Instance 1: default parameters
  logic       en1, rd1, tx1, busy1, done1, empty1;
  logic [7:0] data1;
  logic [7:0] mem1 [16];
  int         wp1, rp1;

  // Instance 2: two stop bits
  logic       en2, rd2, tx2, busy2, done2, empty2;
  logic [7:0] data2;
  logic [7:0] mem2 [16];
  int         wp2, rp2;

  int total, bad;
  int nread1, ndone1;
  int len;
  int rd_base, done_base;

  uart_tx_fifo_drain #(
    .NB_DATA    (8),
    .N_TICK_BIT (NTick),
    .N_STOP_BITS(1)
  ) u_dut1 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_tick      (tick),
    .i_enable    (en1),
    .i_data      (data1),
    .i_fifo_empty(empty1),
    .o_read      (rd1),
    .o_tx        (tx1),
    .o_busy      (busy1),
    .o_tx_done   (done1)
  );

  uart_tx_fifo_drain #(
    .NB_DATA    (8),
    .N_TICK_BIT (NTick),
    .N_STOP_BITS(2)
  ) u_dut2 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_tick      (tick),
    .i_enable    (en2),
    .i_data      (data2),
    .i_fifo_empty(empty2),
    .o_read      (rd2),
    .o_tx        (tx2),
    .o_busy      (busy2),
    .o_tx_done   (done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign empty1 = (wp1 == rp1);
  assign data1  = mem1[rp1[3:0]];
  assign empty2 = (wp2 == rp2);
  assign data2  = mem2[rp2[3:0]];

  always @(posedge clk) begin
    if (rd1) rp1 <= rp1 + 1;
    if (rd2) rp2 <= rp2 + 1;
    if (rd1) nread1 <= nread1 + 1;
    if (done1) ndone1 <= ndone1 + 1;
  end

  always @(posedge clk) begin
    if (tick_div == 0) begin
      tick <= 1'b0;
      tcnt <= 0;
    end else if (tcnt >= tick_div - 1) begin
      tick <= 1'b1;
      tcnt <= 0;
    end else begin
      tick <= 1'b0;
      tcnt <= tcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [3:0] obs(input int d);
    return (d == 0) ? {rd1, busy1, done1, tx1} : {rd2, busy2, done2, tx2};
  endfunction

  task automatic push1(input logic [7:0] v);
    mem1[wp1[3:0]] = v;
    wp1++;
  endtask

  task automatic push2(input logic [7:0] v);
    mem2[wp2[3:0]] = v;
    wp2++;
  endtask

  // Called at a negedge just before the expected load edge. Follows the frame by counting
  // ticks presented to the DUT and returns the cycle count from load edge to done pulse.
  task automatic frame(input int d, input logic [7:0] exp_data, input int nstop,
                       input int drop_at, input string tag, output int cycles);
    int         ticks;
    int         tot;
    int         b;
    logic       t;
    logic       etx;
    logic [3:0] o;
    bit         seen;
    #1;
    o = obs(d);
    chk({tag, "_read_at_load"}, {31'd0, o[3]}, 32'd1);
    tot    = (1 + 8 + nstop) * NTick;
    ticks  = 0;
    seen   = 1'b0;
    cycles = -1;
    @(negedge clk);
    for (int s = 0; s < tot * 8 + 50; s++) begin
      o = obs(d);
      if (ticks == tot) begin
        chk({tag, "_done"}, {29'd0, o[2:0]}, {29'd0, 3'b011});
        cycles = s;
        seen   = 1'b1;
        break;
      end
      b = ticks / NTick;
      if (b == 0) etx = 1'b0;
      else if (b <= 8) etx = exp_data[b-1];
      else etx = 1'b1;
      chk({tag, "_bit"}, {28'd0, o}, {28'd0, 3'b010, etx});
      if (s == drop_at && d == 0) en1 = 1'b0;
      t = tick;
      @(negedge clk);
      if (t) ticks++;
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    total = 0; bad = 0;
    wp1 = 0; rp1 = 0; wp2 = 0; rp2 = 0;
    nread1 = 0; ndone1 = 0;
    tcnt = 0; tick = 1'b0;
    rst = 1'b0;
    en1 = 1'b1; en2 = 1'b0;
    tick_div = 1;
    push1(8'h55);

    // Reset held with FIFO non-empty
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {28'd0, obs(0)}, {28'd0, 4'b0001});
      chk("reset_outputs2", {28'd0, obs(1)}, {28'd0, 4'b0001});
    end

    // Single frame 0x55, tick every cycle
    rst = 1'b1;
    frame(0, 8'h55, 1, -1, "f55", len);
    chk("f55_len", len, 160);
    @(negedge clk);
    chk("f55_done_one_cycle", {28'd0, obs(0)}, {28'd0, 4'b0001});
    chk("f55_one_pop", nread1, 1);

    // Burst at one tick per 4 cycles, 1-cycle IDLE gap between frames
    repeat (3) @(negedge clk);
    tick_div = 4;
    push1(8'hA3);
    push1(8'h0F);
    push1(8'hFF);
    frame(0, 8'hA3, 1, -1, "fA3", len);
    frame(0, 8'h0F, 1, -1, "f0F", len);
    frame(0, 8'hFF, 1, -1, "fFF", len);
    @(negedge clk);
    chk("burst_idle", {28'd0, obs(0)}, {28'd0, 4'b0001});
    chk("burst_pops", nread1, 4);

    // Enable gating
    tick_div = 1;
    en1 = 1'b0;
    push1(8'h81);
    push1(8'h7E);
    repeat (20) begin
      @(negedge clk);
      chk("gated_idle", {28'd0, obs(0)}, {28'd0, 4'b0001});
    end
    en1 = 1'b1;
    frame(0, 8'h81, 1, 5, "f81", len);
    chk("f81_read_after_drop", {31'd0, rd1}, 32'd0);
    repeat (10) @(negedge clk);
    chk("gated_left", wp1 - rp1, 1);
    chk("gated_pops", nread1, 5);
    chk("gated_line", {28'd0, obs(0)}, {28'd0, 4'b0001});
    en1 = 1'b1;
    frame(0, 8'h7E, 1, -1, "f7E", len);

    // Reset during data bit 3 of 0x3C
    repeat (4) @(negedge clk);
    push1(8'h3C);
    #1;
    chk("f3C_read_at_load", {31'd0, rd1}, 32'd1);
    repeat (65) @(negedge clk);
    chk("f3C_bit3", {28'd0, obs(0)}, {28'd0, 4'b0101});
    done_base = ndone1;
    rd_base   = nread1;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("midreset_outputs", {28'd0, obs(0)}, {28'd0, 4'b0001});
    end
    rst = 1'b1;
    repeat (200) begin
      @(negedge clk);
      chk("midreset_after", {28'd0, obs(0)}, {28'd0, 4'b0001});
    end
    chk("midreset_no_done", ndone1, done_base);
    chk("midreset_no_read", nread1, rd_base);

    // Two stop bits, data 0x00
    en2 = 1'b1;
    push2(8'h00);
    frame(1, 8'h00, 2, -1, "f00_2stop", len);
    chk("f00_2stop_len", len, 176);
    @(negedge clk);
    chk("f00_2stop_idle", {28'd0, obs(1)}, {28'd0, 4'b0001});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
